// File: rtl/dvs_fifo_bus_arbiter.sv
// rtl/dvs_fifo_bus_arbiter.sv - round-robin arbiter and write sequencer for the shared event-FIFO write bus
module dvs_fifo_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int EVENT_BITS = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            wr_en_in,
    input  logic [NUM_REQ*EVENT_BITS-1:0] event_in,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wr_en,
    output logic [EVENT_BITS-1:0]         fifo_wdata,
    output logic                          busy,
    output logic                          protocol_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        rr_ptr_next;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        owner_next;
    logic [PW-1:0]        winner;
    logic [PW:0]          cand;
    logic                 found;
    logic [NUM_REQ-1:0]   grant_next;
    logic [NUM_REQ-1:0]   owner_mask;
    logic [NUM_REQ-1:0]   stray_wr;
    logic                 missing_wr;
    logic [EVENT_BITS-1:0] event_arr [NUM_REQ];

    // Unpack the flat event bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign event_arr[g] = event_in[g*EVENT_BITS +: EVENT_BITS];
    end

    // Round-robin search: first requester after rr_ptr, wrapping to 0.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found  = 1'b1;
                winner = cand[PW-1:0];
            end
        end
    end

    // Next-state logic: IDLE decides, GRANT and WRITE each last one cycle.
    always_comb begin
        state_next  = state;
        grant_next  = '0;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: begin
                if (found && !fifo_full) begin
                    grant_next  = NUM_REQ'(1) << winner;
                    owner_next  = winner;
                    rr_ptr_next = winner;
                    state_next  = GRANT;
                end
            end
            GRANT:   state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO port forwarding and protocol-violation detection.
    always_comb begin
        owner_mask = NUM_REQ'(1) << owner;
        fifo_wr_en = (state == WRITE) && wr_en_in[owner];
        fifo_wdata = (state == WRITE) ? event_arr[owner] : '0;
        busy       = (state != IDLE);
        stray_wr   = (state == WRITE) ? (wr_en_in & ~owner_mask) : wr_en_in;
        missing_wr = (state == WRITE) && !wr_en_in[owner];
    end

    // State, grant, ownership and sticky error registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            owner        <= '0;
            rr_ptr       <= PW'(NUM_REQ-1);
            protocol_err <= 1'b0;
        end else begin
            state        <= state_next;
            grant        <= grant_next;
            owner        <= owner_next;
            rr_ptr       <= rr_ptr_next;
            protocol_err <= protocol_err | (|stray_wr) | missing_wr;
        end
    end

endmodule

// File: tb/tb_dvs_fifo_bus_arbiter.sv
// tb/tb_dvs_fifo_bus_arbiter.sv - scoreboard testbench for dvs_fifo_bus_arbiter
module tb_dvs_fifo_bus_arbiter;

    localparam int N  = 4;
    localparam int EB = 32;

    typedef struct {
        bit            is_wr;
        logic [N-1:0]  g;
        logic [EB-1:0] d;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N-1:0]  wr_en_in;
    logic [N*EB-1:0] event_in;
    logic          fifo_full;
    logic [N-1:0]  grant;
    logic          fifo_wr_en;
    logic [EB-1:0] fifo_wdata;
    logic          busy;
    logic          protocol_err;

    dvs_fifo_bus_arbiter #(.NUM_REQ(N), .EVENT_BITS(EB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr_en_in(wr_en_in),
        .event_in(event_in), .fifo_full(fifo_full), .grant(grant),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .busy(busy),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [N-1:0]  pend = '0;
    logic [N-1:0]  mute = '0;
    logic [N-1:0]  inject = '0;
    logic [N-1:0]  auto_mask = '0;
    logic [EB-1:0] ev [N];
    int            pct = 0;
    bit            rand_full = 1'b0;
    bit            mon_on = 1'b0;
    int            wr_owner = -1;
    exp_t          exp_q [$];
    exp_t          mon_it;
    logic [N-1:0]  glog [$];
    int            gcyc [$];

    int m_ptr, m_free, m_busy_until, m_wr_edge, m_wr_owner;
    bit m_err;

    assign req = pend;
    for (genvar g = 0; g < N; g++) begin : g_ev
        assign event_in[g*EB +: EB] = ev[g];
    end

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic raise(input int i);
        pend[i] = 1'b1;
        ev[i]   = $urandom;
    endtask

    // One clock: reference model at the edge, then requester behaviour.
    task automatic step();
        logic [N-1:0] allowed;
        int w;
        int wrote;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_ptr = N-1; m_free = cyc+1; m_busy_until = cyc-1;
            m_wr_edge = -1; m_err = 1'b0;
            exp_q.delete();
        end else begin
            allowed = (cyc == m_wr_edge) ? (N'(1) << m_wr_owner) : '0;
            if ((wr_en_in & ~allowed) != '0) m_err = 1'b1;
            if (cyc == m_wr_edge && !wr_en_in[m_wr_owner]) m_err = 1'b1;
            if (cyc >= m_free && req != '0 && !fifo_full) begin
                w = -1;
                for (int j = 1; j <= N; j++)
                    if (w < 0 && req[(m_ptr+j)%N]) w = (m_ptr+j)%N;
                m_ptr = w;
                exp_q.push_back('{is_wr:1'b0, g:(N'(1) << w), d:'0, cyc:cyc});
                if (!mute[w]) exp_q.push_back('{is_wr:1'b1, g:'0, d:ev[w], cyc:cyc+1});
                m_busy_until = cyc+1; m_free = cyc+3; m_wr_edge = cyc+2; m_wr_owner = w;
            end
        end
        #1;
        wrote = -1;
        wr_en_in = inject;
        inject = '0;
        if (!rst_n) begin
            wr_owner = -1;
            pend = '0;
        end else if (wr_owner >= 0) begin
            if (!mute[wr_owner]) wr_en_in[wr_owner] = 1'b1;
            pend[wr_owner] = 1'b0;
            wrote = wr_owner;
            wr_owner = -1;
        end else if (grant != '0) begin
            for (int i = 0; i < N; i++) if (grant[i]) wr_owner = i;
        end
        for (int i = 0; i < N; i++)
            if (auto_mask[i] && !pend[i] && i != wrote && $urandom_range(99) < pct) raise(i);
        if (rand_full) fifo_full = ($urandom_range(3) == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || busy || pend != '0) && k < 60) begin
            step();
            k++;
        end
        chk(k < 60, "drain_timeout", k, 60);
        step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a write.
    always @(negedge clk) begin
        if (mon_on) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                mon_it = exp_q.pop_front();
                chk(1'b0, "missing_output", 0, mon_it.is_wr ? 64'(mon_it.d) : 64'(mon_it.g));
            end
            if (grant != '0) begin
                glog.push_back(grant);
                gcyc.push_back(cyc);
                if (exp_q.size() == 0) chk(1'b0, "unexpected_grant", grant, 0);
                else begin
                    mon_it = exp_q.pop_front();
                    chk(!mon_it.is_wr && mon_it.g == grant, "grant", grant, mon_it.g);
                    chk(mon_it.cyc == cyc, "grant_cycle", cyc, mon_it.cyc);
                end
            end
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_write", fifo_wdata, 0);
                else begin
                    mon_it = exp_q.pop_front();
                    chk(mon_it.is_wr && mon_it.d == fifo_wdata, "write_data", fifo_wdata, mon_it.d);
                    chk(mon_it.cyc == cyc, "write_cycle", cyc, mon_it.cyc);
                end
            end
            chk(busy == (cyc <= m_busy_until), "busy", busy, (cyc <= m_busy_until));
            chk(protocol_err == m_err, "protocol_err", protocol_err, m_err);
            if (!busy) chk(fifo_wdata == '0, "wdata_idle", fifo_wdata, 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        rst_n = 1'b0; wr_en_in = '0; fifo_full = 1'b0;
        for (int i = 0; i < N; i++) ev[i] = '0;
        step(); step();
        chk(grant == '0, "reset_grant", grant, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);
        chk(fifo_wr_en == 1'b0, "reset_wr_en", fifo_wr_en, 0);
        chk(fifo_wdata == '0, "reset_wdata", fifo_wdata, 0);
        chk(protocol_err == 1'b0, "reset_err", protocol_err, 0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Single requester: grant one cycle after req, write the cycle after.
        glog.delete(); gcyc.delete();
        c0 = cyc;
        raise(0);
        drain();
        chk(glog.size() > 0 && glog[0] == 4'b0001, "t1_grant", glog.size() > 0 ? glog[0] : '0, 4'b0001);
        chk(gcyc.size() > 0 && gcyc[0] == c0+1, "t1_grant_cycle", gcyc.size() > 0 ? gcyc[0] : -1, c0+1);

        // All requesters held high: strict rotation, one grant every 3 cycles.
        do_reset();
        glog.delete(); gcyc.delete();
        c0 = cyc;
        for (int i = 0; i < N; i++) raise(i);
        auto_mask = '1; pct = 100;
        repeat (14) step();
        auto_mask = '0;
        drain();
        for (int i = 0; i < 5; i++) begin
            chk(glog.size() > i && glog[i] == (N'(1) << (i % N)), "t2_rotation",
                glog.size() > i ? glog[i] : '0, N'(1) << (i % N));
            chk(gcyc.size() > i && gcyc[i] == c0+1+3*i, "t2_spacing",
                gcyc.size() > i ? gcyc[i] : -1, c0+1+3*i);
        end

        // Pointer at 2, requests 0 and 2: wrap past 3 to 0.
        do_reset();
        raise(2);
        drain();
        glog.delete(); gcyc.delete();
        raise(0); raise(2);
        drain();
        chk(glog.size() > 0 && glog[0] == 4'b0001, "t3_wrap", glog.size() > 0 ? glog[0] : '0, 4'b0001);

        // FIFO full blocks granting; release grants one cycle later.
        fifo_full = 1'b1;
        raise(1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk(grant == '0 && !fifo_wr_en, "t4_full_hold", {grant, fifo_wr_en}, 0);
        end
        fifo_full = 1'b0;
        step();
        chk(grant == 4'b0010, "t4_grant_after_full", grant, 4'b0010);
        drain();

        // Reset during GRANT abandons the transaction.
        raise(3);
        k = 0;
        while (grant == '0 && k < 10) begin step(); k++; end
        chk(grant == 4'b1000, "t6_grant", grant, 4'b1000);
        rst_n = 1'b0;
        step();
        chk(grant == '0, "t6_grant_after_reset", grant, 0);
        chk(busy == 1'b0, "t6_busy_after_reset", busy, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk(!fifo_wr_en, "t6_no_write", fifo_wr_en, 0);
        end

        // Stray write strobe while IDLE sets the sticky error.
        inject = 4'b0010;
        step();
        chk(!fifo_wr_en, "t5_stray_not_forwarded", fifo_wr_en, 0);
        step();
        chk(protocol_err == 1'b1, "t5_err_stray", protocol_err, 1);
        repeat (5) step();
        chk(protocol_err == 1'b1, "t5_err_held", protocol_err, 1);
        do_reset();
        chk(protocol_err == 1'b0, "t5_err_cleared", protocol_err, 0);

        // Owner 2 silent in WRITE: no FIFO write, sticky error.
        mute = 4'b0100;
        raise(2);
        drain();
        mute = '0;
        repeat (3) step();
        chk(protocol_err == 1'b1, "t5_err_missing", protocol_err, 1);
        do_reset();
        chk(protocol_err == 1'b0, "t5_err_cleared2", protocol_err, 0);

        // Randomized traffic with random FIFO backpressure.
        glog.delete(); gcyc.delete();
        auto_mask = '1; pct = 30; rand_full = 1'b1;
        repeat (3000) step();
        auto_mask = '0; rand_full = 1'b0; fifo_full = 1'b0;
        drain();
        chk(glog.size() > 200, "random_grant_count", glog.size(), 200);
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
